// File: rtl/rr_arb16_sel.sv
// 16-way round-robin arbiter emitting a registered grant index (sel) and grant valid (en).
// Optional hold-timeout release is enabled with the ARB_TIMEOUT_EN macro.
module rr_arb16_sel #(
    parameter int unsigned HOLD_MAX = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        ack,
    output logic [3:0]  sel,
    output logic        en,
    output logic        timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit PARAMS_OK = (HOLD_MAX >= 1) && (HOLD_MAX <= 65535) &&
                               (CNT_W >= 1) && (CNT_W <= 32) &&
                               ((64'd1 << CNT_W) > 64'(HOLD_MAX));

    state_t      state_q, state_d;
    logic [3:0]  ptr_q,   ptr_d;
    logic [3:0]  sel_q,   sel_d;
    logic        en_q,    en_d;

    logic        pick_vld;
    logic [3:0]  pick_idx;

    // Search upward from ptr, wrapping 15 -> 0; the 4-bit add provides the wrap.
    always_comb begin
        logic [3:0] idx;
        pick_vld = 1'b0;
        pick_idx = 4'h0;
        idx      = 4'h0;
        for (int i = 0; i < 16; i++) begin
            idx = ptr_q + 4'(i);
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_idx = idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        en_d    = en_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick_idx;
                    en_d    = 1'b1;
                    state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                // Releasing moves the pointer past the winner so it ranks last next time.
                if (ack) begin
                    en_d    = 1'b0;
                    ptr_d   = sel_q + 4'd1;
                    state_d = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == HOLD_LAST) begin
                    en_d      = 1'b0;
                    ptr_d     = sel_q + 4'd1;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 4'h0;
            sel_q   <= 4'h0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign sel = sel_q;
    assign en  = en_q;

    a_params_ok: assert property (@(posedge clk) PARAMS_OK);

    a_en_matches_state: assert property (@(posedge clk) en_q == (state_q == GRANT));

    a_sel_stable_in_grant: assert property (@(posedge clk) disable iff (rst)
        (state_q == GRANT) |=> $stable(sel_q));

endmodule
